// File: rtl/router_reg_gen.sv
// Router register block: captures the header, steers header/payload/held bytes to the output FIFO, and checks each packet.
// Latency: dout updates one clock after the lfd/ld/laf state is sampled; err/len_err follow parity_done by one clock.
// Backpressure: fifo_full parks the current byte in a hold register and keeps dout; laf_state releases the parked byte.
module router_reg_gen #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int CHK_MODE = 0,
    parameter int CNT_W    = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_count
);

    // LEN occupies the header bits above the address; the payload counter
    // carries one extra bit so an overlong packet cannot wrap back onto LEN.
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PCNT_W = LEN_W + 1;

    logic [DATA_W-1:0] header_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] chk_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic              pd_seen_q;

    logic              lfd_go;
    logic              ld_go;
    logic              laf_go;
    logic              addr_ok;
    logic              hdr_load;
    logic              fold_en;
    logic              chk_load;
    logic              pd_set;
    logic              pd_rise;
    logic              acc_mismatch;
    logic              len_mismatch;
    logic [DATA_W-1:0] acc_fold;
    logic [LEN_W-1:0]  len_field;

    // detect_add starts a new packet, so it masks every other state input.
    assign lfd_go = lfd_state & ~detect_add;
    assign ld_go  = ld_state  & ~detect_add;
    assign laf_go = laf_state & ~detect_add;

    // The all-ones address is reserved and never accepted as a destination.
    assign addr_ok  = (data_in[ADDR_W-1:0] != {ADDR_W{1'b1}});
    assign hdr_load = detect_add & pkt_valid & addr_ok;

    // Payload bytes count only while the FIFO path is not stalled; a pkt_valid
    // drop during load marks the current byte as the packet check byte.
    assign fold_en  = ld_go & pkt_valid & ~full_state;
    assign chk_load = ld_go & ~pkt_valid;

    // The check byte is done either when it goes straight out, or when it was
    // parked by fifo_full and is later released from the hold register.
    assign pd_set = (ld_go & ~fifo_full & ~pkt_valid)
                  | (laf_go & low_pkt_valid & ~parity_done);

    // Checks are evaluated once, on the clock after parity_done first rises.
    assign pd_rise = parity_done & ~pd_seen_q;

    assign len_field    = header_q[DATA_W-1:ADDR_W];
    assign acc_mismatch = (acc_q != chk_q);
    assign len_mismatch = (pcnt_q != {1'b0, len_field});

    // Fold operator selected by CHK_MODE: XOR parity or modulo-2^DATA_W sum.
    always_comb begin
        acc_fold = acc_q ^ data_in;
        if (CHK_MODE == 1) begin
            acc_fold = acc_q + data_in;
        end
    end

    // Header capture for valid destinations only.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            header_q <= '0;
        end else if (hdr_load) begin
            header_q <= data_in;
        end
    end

    // Output data steering: header, live payload, or the byte parked during a full FIFO.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout   <= '0;
            hold_q <= '0;
        end else if (lfd_go) begin
            dout <= header_q;
        end else if (ld_go && !fifo_full) begin
            dout <= data_in;
        end else if (ld_go && fifo_full) begin
            hold_q <= data_in;
        end else if (laf_go) begin
            dout <= hold_q;
        end
    end

    // Running check accumulator, seeded with the header on the first-data cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (detect_add) begin
            acc_q <= '0;
        end else if (lfd_go) begin
            acc_q <= header_q;
        end else if (fold_en) begin
            acc_q <= acc_fold;
        end
    end

    // Saturating payload byte counter, compared against LEN at check time.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else if (detect_add) begin
            pcnt_q <= '0;
        end else if (fold_en && !(&pcnt_q)) begin
            pcnt_q <= pcnt_q + {{(PCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Check byte latch; it is only consumed after parity_done, so it is not cleared per packet.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            chk_q <= '0;
        end else if (chk_load) begin
            chk_q <= data_in;
        end
    end

    // low_pkt_valid is owned by the controller: set on pkt_valid drop, cleared only by rst_int_reg.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (chk_load) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // parity_done is sticky for the rest of the packet; pd_seen_q tracks its previous value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            parity_done <= 1'b0;
            pd_seen_q   <= 1'b0;
        end else begin
            pd_seen_q <= parity_done;
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (pd_set) begin
                parity_done <= 1'b1;
            end
        end
    end

    // Error flags are computed once per packet and held until the next header.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            err     <= 1'b0;
            len_err <= 1'b0;
        end else if (detect_add) begin
            err     <= 1'b0;
            len_err <= 1'b0;
        end else if (pd_rise) begin
            err     <= acc_mismatch;
            len_err <= len_mismatch;
        end
    end

    // Saturating count of bad packets; survives detect_add and only clears on reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_count <= '0;
        end else if (!detect_add && pd_rise && (acc_mismatch || len_mismatch)
                     && !(&err_count)) begin
            err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench for router_reg_gen: XOR-mode and sum-mode instances share one stimulus stream.
// Each vector is applied before a rising edge and the selected instance is sampled 1ns after it.
// Long packets use a small bench model for the expected check byte and replayed data.
module tb_router_reg_gen;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full, rst_int_reg;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1, cnt0, cnt1;
    logic       err0, err1, pd0, pd1, lpv0, lpv1, lerr0, lerr1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0), .CNT_W(8)) u_dut0 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .dout(dout0), .err(err0), .parity_done(pd0),
        .low_pkt_valid(lpv0), .len_err(lerr0), .err_count(cnt0)
    );

    router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(1), .CNT_W(8)) u_dut1 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .dout(dout1), .err(err1), .parity_done(pd1),
        .low_pkt_valid(lpv1), .len_err(lerr1), .err_count(cnt1)
    );

    typedef struct {
        logic       rn, pv;
        logic [7:0] d;
        logic       ff, ri, da, lfd, ld, laf, full;
        logic       sel;
        logic [7:0] e_dout;
        logic       e_err, e_pd, e_lpv, e_lerr;
        logic [7:0] e_cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t       tv [NV];
    logic [7:0] pl [16];

    function automatic vec_t v(input int rn, pv, d, ff, ri, da, lfd, ld, laf, full,
                               sel, ed, ee, ep, el, elr, ec);
        vec_t r;
        r.rn = rn[0];   r.pv = pv[0];   r.d = d[7:0];     r.ff = ff[0];
        r.ri = ri[0];   r.da = da[0];   r.lfd = lfd[0];   r.ld = ld[0];
        r.laf = laf[0]; r.full = full[0]; r.sel = sel[0];
        r.e_dout = ed[7:0]; r.e_err = ee[0]; r.e_pd = ep[0];
        r.e_lpv = el[0];    r.e_lerr = elr[0]; r.e_cnt = ec[7:0];
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rn, pv, input logic [7:0] d,
                         input logic ff, ri, da, lfd, ld, laf, full);
        resetn = rn; pkt_valid = pv; data_in = d; fifo_full = ff; rst_int_reg = ri;
        detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf; full_state = full;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete packet on the XOR-mode instance, payload taken from pl[].
    task automatic run_pkt0(input logic [7:0] hdr, input int n, input logic bad,
                            input logic exp_err, input logic exp_lerr, input logic [7:0] exp_cnt);
        logic [7:0] acc;
        logic [7:0] chk;
        acc = hdr;
        for (int i = 0; i < n; i++) acc = acc ^ pl[i];
        chk = bad ? ~acc : acc;
        drive(1, 1, hdr, 0, 0, 1, 0, 0, 0, 0); tick();
        check("pkt_da_pd", 32'(pd0), 0);
        drive(1, 1, pl[0], 0, 0, 0, 1, 0, 0, 0); tick();
        check("pkt_lfd_dout", 32'(dout0), 32'(hdr));
        for (int i = 0; i < n; i++) begin
            drive(1, 1, pl[i], 0, 0, 0, 0, 1, 0, 0); tick();
            check("pkt_ld_dout", 32'(dout0), 32'(pl[i]));
        end
        drive(1, 0, chk, 0, 0, 0, 0, 1, 0, 0); tick();
        check("pkt_chk_dout", 32'(dout0), 32'(chk));
        check("pkt_chk_pd", 32'(pd0), 1);
        check("pkt_chk_lpv", 32'(lpv0), 1);
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0); tick();
        check("pkt_err", 32'(err0), 32'(exp_err));
        check("pkt_len_err", 32'(lerr0), 32'(exp_lerr));
        check("pkt_err_count", 32'(cnt0), 32'(exp_cnt));
        drive(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0); tick();
        check("pkt_rst_int_lpv", 32'(lpv0), 0);
    endtask

    initial begin
        //           rn pv d     ff ri da lfd ld laf full sel dout  err pd lpv lerr cnt
        tv[0]  = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
        tv[1]  = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0, 0, 0, 0, 0);
        tv[2]  = v(1, 1, 'h05, 0, 0, 1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
        tv[3]  = v(1, 1, 'h0F, 0, 0, 1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0);
        tv[4]  = v(1, 1, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 'h05, 0, 0, 0, 0, 0);
        tv[5]  = v(1, 1, 'h11, 0, 0, 0, 0, 1, 0, 0, 0, 'h11, 0, 0, 0, 0, 0);
        tv[6]  = v(1, 1, 'hA5, 1, 0, 0, 0, 1, 0, 1, 0, 'h11, 0, 0, 0, 0, 0);
        tv[7]  = v(1, 1, 'h33, 0, 0, 0, 0, 0, 1, 0, 0, 'hA5, 0, 0, 0, 0, 0);
        tv[8]  = v(1, 0, 'h14, 0, 0, 0, 0, 1, 0, 0, 0, 'h14, 0, 1, 1, 0, 0);
        tv[9]  = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 'h14, 0, 1, 1, 0, 0);
        tv[10] = v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 0, 'h14, 0, 1, 0, 0, 0);
        tv[11] = v(1, 0, 'h5A, 0, 1, 0, 0, 1, 0, 0, 0, 'h5A, 0, 1, 0, 0, 0);
        tv[12] = v(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0, 0, 0, 0, 0);
        tv[13] = v(1, 1, 'h09, 0, 0, 1, 0, 0, 0, 0, 1, 'h00, 0, 0, 0, 0, 0);
        tv[14] = v(1, 1, 'hFF, 0, 0, 0, 1, 0, 0, 0, 1, 'h09, 0, 0, 0, 0, 0);
        tv[15] = v(1, 1, 'hFF, 0, 0, 0, 0, 1, 0, 0, 1, 'hFF, 0, 0, 0, 0, 0);
        tv[16] = v(1, 1, 'h02, 0, 0, 0, 0, 1, 0, 0, 1, 'h02, 0, 0, 0, 0, 0);
        tv[17] = v(1, 0, 'h0A, 0, 0, 0, 0, 1, 0, 0, 1, 'h0A, 0, 1, 1, 0, 0);
        tv[18] = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 'h0A, 0, 1, 1, 0, 0);
        tv[19] = v(1, 0, 'h00, 0, 1, 0, 0, 0, 0, 0, 1, 'h0A, 0, 1, 0, 0, 0);
        tv[20] = v(1, 1, 'h0D, 0, 0, 1, 0, 0, 0, 0, 1, 'h0A, 0, 0, 0, 0, 0);
        tv[21] = v(1, 1, 'h01, 0, 0, 0, 1, 0, 0, 0, 1, 'h0D, 0, 0, 0, 0, 0);
        tv[22] = v(1, 1, 'h01, 0, 0, 0, 0, 1, 0, 0, 1, 'h01, 0, 0, 0, 0, 0);
        tv[23] = v(1, 1, 'h02, 0, 0, 0, 0, 1, 0, 0, 1, 'h02, 0, 0, 0, 0, 0);
        tv[24] = v(1, 1, 'h03, 0, 0, 0, 0, 1, 0, 0, 1, 'h03, 0, 0, 0, 0, 0);
        tv[25] = v(1, 1, 'h04, 0, 0, 0, 0, 1, 0, 0, 1, 'h04, 0, 0, 0, 0, 0);
        tv[26] = v(1, 0, 'h17, 0, 0, 0, 0, 1, 0, 0, 1, 'h17, 0, 1, 1, 0, 0);
        tv[27] = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 'h17, 0, 1, 1, 1, 1);
        tv[28] = v(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 'h17, 0, 1, 1, 1, 1);
        tv[29] = v(1, 1, 'h0F, 0, 0, 1, 0, 1, 0, 0, 1, 'h17, 0, 0, 1, 0, 1);

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rn, tv[i].pv, tv[i].d, tv[i].ff, tv[i].ri,
                  tv[i].da, tv[i].lfd, tv[i].ld, tv[i].laf, tv[i].full);
            tick();
            if (tv[i].sel) begin
                check($sformatf("v%0d_dout", i), 32'(dout1), 32'(tv[i].e_dout));
                check($sformatf("v%0d_err", i), 32'(err1), 32'(tv[i].e_err));
                check($sformatf("v%0d_pd", i), 32'(pd1), 32'(tv[i].e_pd));
                check($sformatf("v%0d_lpv", i), 32'(lpv1), 32'(tv[i].e_lpv));
                check($sformatf("v%0d_len_err", i), 32'(lerr1), 32'(tv[i].e_lerr));
                check($sformatf("v%0d_err_count", i), 32'(cnt1), 32'(tv[i].e_cnt));
            end else begin
                check($sformatf("v%0d_dout", i), 32'(dout0), 32'(tv[i].e_dout));
                check($sformatf("v%0d_err", i), 32'(err0), 32'(tv[i].e_err));
                check($sformatf("v%0d_pd", i), 32'(pd0), 32'(tv[i].e_pd));
                check($sformatf("v%0d_lpv", i), 32'(lpv0), 32'(tv[i].e_lpv));
                check($sformatf("v%0d_len_err", i), 32'(lerr0), 32'(tv[i].e_lerr));
                check($sformatf("v%0d_err_count", i), 32'(cnt0), 32'(tv[i].e_cnt));
            end
        end

        // XOR mode, header 0x3D (LEN 15, addr 1) with 15 random payload bytes.
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        drive(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        run_pkt0(8'h3D, 15, 1'b0, 1'b0, 1'b0, 8'd0);
        run_pkt0(8'h3D, 15, 1'b1, 1'b1, 1'b0, 8'd1);

        // Next header clears err but keeps the tally; this packet is then aborted by reset.
        drive(1, 1, 8'h3D, 0, 0, 1, 0, 0, 0, 0); tick();
        check("next_da_err", 32'(err0), 0);
        check("next_da_err_count", 32'(cnt0), 1);
        drive(1, 1, pl[0], 0, 0, 0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, pl[i], 0, 0, 0, 0, 1, 0, 0); tick();
        end
        check("mid_dout_before_reset", 32'(dout0), 32'(pl[4]));
        drive(0, 1, pl[5], 0, 0, 0, 0, 1, 0, 0); tick();
        check("rst_dout", 32'(dout0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_pd", 32'(pd0), 0);
        check("rst_lpv", 32'(lpv0), 0);
        check("rst_len_err", 32'(lerr0), 0);
        check("rst_err_count", 32'(cnt0), 0);

        // Clean packet straight after reset release.
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
        run_pkt0(8'h3D, 15, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
